// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP,
        GAP
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;
    localparam logic [1:0] EOP_BITS    = 2'd2;
    localparam logic [1:0] GAP_BITS    = 2'd1;

endpackage

// File: rtl/usb_tx_if.sv
// Byte handshake between the packet source and the serializer.
interface usb_tx_if;

    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_accept;

    modport master (
        output tx_byte,
        output tx_valid,
        output tx_last,
        input  tx_accept
    );

    modport slave (
        input  tx_byte,
        input  tx_valid,
        input  tx_last,
        output tx_accept
    );

endinterface

// File: rtl/usb_tx_bit_stuffer_timer.sv
// Bit-period timer: clk counter, period boundary and bit_en strobe.
module usb_bit_timer #(
    parameter int CLK_PER_BIT = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic start,
    input  logic busy_nxt,
    output logic boundary,
    output logic bit_en
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_en_q, bit_en_d;

    always_comb begin
        boundary = en & (cnt_q == LAST);
        cnt_d    = cnt_q + 1'b1;
        if (!en || boundary) begin
            cnt_d = '0;
        end
        // strobe is only meaningful when a period spans several clks
        bit_en_d = (CLK_PER_BIT > 1) & busy_nxt & (start | boundary);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q    <= '0;
            bit_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bit_en_q <= bit_en_d;
        end
    end

    assign bit_en = bit_en_q;

endmodule

// File: rtl/usb_tx_bit_stuffer.sv
// USB TX serializer: SYNC, LSB-first data with bit stuffing, EOP and idle gap.
module usb_tx_bit_stuffer #(
    parameter int CLK_PER_BIT = 1
) (
    input  logic    clk,
    input  logic    n_rst,
    usb_tx_if.slave tx,
    output logic    data,
    output logic    ready,
    output logic    eop,
    output logic    bit_en,
    output logic    busy,
    output logic    underrun
);
    import usb_tx_pkg::*;

    tx_state_t  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] ones_q, ones_d;
    logic [1:0] eopc_q, eopc_d;
    logic       last_q, last_d;
    logic       data_q, data_d;
    logic       ready_q, ready_d;
    logic       eop_q, eop_d;
    logic       busy_q, busy_d;
    logic       underrun_q, underrun_d;

    logic       boundary, adv, start;
    logic       byte_end, load_pt, to_eop;
    logic [2:0] ones_nxt;

    usb_bit_timer #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (busy_q),
        .start    (start),
        .busy_nxt (busy_d),
        .boundary (boundary),
        .bit_en   (bit_en)
    );

    assign start    = (state_q == IDLE) & tx.tx_valid;
    assign adv      = busy_q & boundary;
    assign ones_nxt = data_q ? ones_q + 3'd1 : 3'd0;

    // a byte ends once its last bit and any stuff bit after it are sent
    assign byte_end = adv & (idx_q == 3'd7) &
                      (((state_q == DATA) & (ones_nxt != STUFF_LIMIT)) |
                       (state_q == STUFF));
    assign load_pt  = (adv & (state_q == SYNC) & (idx_q == 3'd7)) |
                      (byte_end & ~last_q);

    assign tx.tx_accept = load_pt & tx.tx_valid;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        ones_d     = ones_q;
        eopc_d     = eopc_q;
        last_d     = last_q;
        data_d     = data_q;
        ready_d    = ready_q;
        eop_d      = eop_q;
        busy_d     = busy_q;
        underrun_d = 1'b0;
        to_eop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SYNC;
                    idx_d   = '0;
                    ones_d  = '0;
                    eopc_d  = '0;
                    data_d  = SYNC_BYTE[0];
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SYNC: begin
                if (adv && idx_q != 3'd7) begin
                    idx_d  = idx_q + 3'd1;
                    data_d = SYNC_BYTE[idx_q + 3'd1];
                end
            end
            DATA: begin
                if (adv) begin
                    ones_d = ones_nxt;
                    if (ones_nxt == STUFF_LIMIT) begin
                        state_d = STUFF;
                        data_d  = 1'b0;
                    end else if (idx_q != 3'd7) begin
                        idx_d   = idx_q + 3'd1;
                        data_d  = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            STUFF: begin
                if (adv) begin
                    ones_d = '0;
                    if (idx_q != 3'd7) begin
                        state_d = DATA;
                        idx_d   = idx_q + 3'd1;
                        data_d  = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            EOP: begin
                if (adv) begin
                    if (eopc_q == EOP_BITS - 2'd1) begin
                        state_d = GAP;
                        eop_d   = 1'b0;
                        eopc_d  = '0;
                    end else begin
                        eopc_d  = eopc_q + 2'd1;
                    end
                end
            end
            GAP: begin
                if (adv) begin
                    if (eopc_q == GAP_BITS - 2'd1) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        eopc_d  = '0;
                    end else begin
                        eopc_d  = eopc_q + 2'd1;
                    end
                end
            end
            default: ;
        endcase

        if (load_pt) begin
            if (tx.tx_valid) begin
                state_d = DATA;
                idx_d   = '0;
                data_d  = tx.tx_byte[0];
                shreg_d = {1'b0, tx.tx_byte[7:1]};
                last_d  = tx.tx_last;
                if (state_q == SYNC) begin
                    ones_d = 3'd1;
                end
            end else begin
                underrun_d = 1'b1;
                to_eop     = 1'b1;
            end
        end else if (byte_end) begin
            to_eop = 1'b1;
        end

        if (to_eop) begin
            state_d = EOP;
            data_d  = 1'b0;
            ready_d = 1'b0;
            eop_d   = 1'b1;
            eopc_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            ones_q     <= '0;
            eopc_q     <= '0;
            last_q     <= 1'b0;
            data_q     <= 1'b0;
            ready_q    <= 1'b0;
            eop_q      <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            ones_q     <= ones_d;
            eopc_q     <= eopc_d;
            last_q     <= last_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            eop_q      <= eop_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign data     = data_q;
    assign ready    = ready_q;
    assign eop      = eop_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_usb_tx_bit_stuffer.sv
// Bench for usb_tx_bit_stuffer: directed and random packets vs a period-list model.
module tb_usb_tx_bit_stuffer;

    typedef struct packed {
        logic data;
        logic ready;
        logic eop;
        logic busy;
        logic und;
        logic acc;
        logic ben;
    } smp_t;

    typedef struct packed {
        logic data;
        logic ready;
        logic eop;
        logic acc;
        logic und;
    } per_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       sel;
    logic [7:0] tb_byte;
    logic       tb_valid;
    logic       tb_last;

    usb_tx_if if1 ();
    usb_tx_if if4 ();

    assign if1.tx_byte  = tb_byte;
    assign if1.tx_last  = tb_last;
    assign if1.tx_valid = tb_valid & ~sel;
    assign if4.tx_byte  = tb_byte;
    assign if4.tx_last  = tb_last;
    assign if4.tx_valid = tb_valid & sel;

    logic d1, r1, e1, b1, y1, u1;
    logic d4, r4, e4, b4, y4, u4;

    usb_tx_bit_stuffer #(.CLK_PER_BIT(1)) dut1 (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx       (if1),
        .data     (d1),
        .ready    (r1),
        .eop      (e1),
        .bit_en   (b1),
        .busy     (y1),
        .underrun (u1)
    );

    usb_tx_bit_stuffer #(.CLK_PER_BIT(4)) dut4 (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx       (if4),
        .data     (d4),
        .ready    (r4),
        .eop      (e4),
        .bit_en   (b4),
        .busy     (y4),
        .underrun (u4)
    );

    smp_t obs;
    assign obs = sel ? {d4, r4, e4, y4, u4, if4.tx_accept, b4}
                     : {d1, r1, e1, y1, u1, if1.tx_accept, b1};

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] pkts [32][4];
    int         pn [32];
    int         pk [32];

    smp_t exq [256];
    int   ne;

    int          c_busy, c_ready, c_acc, c_und, c_ben;
    logic [31:0] stream;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        ntests++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic mk(input int p, input int n, input int k,
                      input logic [7:0] a, input logic [7:0] b);
        pn[p] = n;
        pk[p] = k;
        pkts[p][0] = a;
        pkts[p][1] = b;
        pkts[p][2] = 8'h00;
        pkts[p][3] = 8'h00;
    endtask

    task automatic gen(input int p);
        pn[p] = int'($urandom_range(1, 4));
        pk[p] = pn[p];
        if (pn[p] > 1 && $urandom_range(0, 3) == 0)
            pk[p] = int'($urandom_range(1, pn[p] - 1));
        for (int j = 0; j < 4; j++)
            pkts[p][j] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
    endtask

    // Expected line activity: list of bit periods, then expanded to clks.
    task automatic build(input int p, input int nb);
        per_t per [64];
        int   np;
        int   ones;
        logic b;
        logic und;
        np   = 0;
        ones = 1;
        und  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            per[np] = {i == 7, 1'b1, 3'b000};
            np++;
        end
        for (int j = 0; j < pn[p]; j++) begin
            if (j < pk[p]) begin
                per[np-1].acc = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    b = pkts[p][j][k];
                    per[np] = {b, 1'b1, 3'b000};
                    np++;
                    ones = b ? ones + 1 : 0;
                    if (ones == 6) begin
                        per[np] = 5'b01000;
                        np++;
                        ones = 0;
                    end
                end
            end else if (j == pk[p]) begin
                und = 1'b1;
            end
        end
        per[np] = {4'b0010, und};
        np++;
        per[np] = 5'b00100;
        np++;
        per[np] = 5'b00000;
        np++;
        ne = 0;
        exq[ne] = '0;
        ne++;
        for (int i = 0; i < np; i++) begin
            for (int c = 0; c < nb; c++) begin
                exq[ne] = {per[i].data, per[i].ready, per[i].eop, 1'b1,
                           per[i].und & (c == 0),
                           per[i].acc & (c == nb - 1),
                           (nb > 1) & (c == 0)};
                ne++;
            end
        end
    endtask

    task automatic present(input int p, input int j);
        tb_byte  = pkts[p][j];
        tb_last  = (j == pn[p] - 1);
        tb_valid = 1'b1;
    endtask

    task automatic run_packet(input int p, input int nb, input bit pre);
        int   si;
        logic xfer;
        build(p, nb);
        c_busy  = 0;
        c_ready = 0;
        c_acc   = 0;
        c_und   = 0;
        c_ben   = 0;
        stream  = '0;
        if (!tb_valid) present(p, 0);
        si = 0;
        for (int i = 0; i < ne; i++) begin
            @(negedge clk);
            ntests++;
            assert (obs === exq[i]) else begin
                nfail++;
                $error("FAIL pkt%0d clk%0d observed=%b expected=%b",
                       p, i, obs, exq[i]);
            end
            c_busy  += int'(obs.busy);
            c_ready += int'(obs.ready);
            c_acc   += int'(obs.acc);
            c_und   += int'(obs.und);
            c_ben   += int'(obs.ben);
            if (obs.ready) stream = {stream[30:0], obs.data};
            xfer = obs.acc & tb_valid;
            @(posedge clk);
            #1;
            if (xfer) begin
                si++;
                if (si < pk[p]) begin
                    present(p, si);
                end else if (pre && pk[p] == pn[p]) begin
                    present(p + 1, 0);
                end else begin
                    tb_valid = 1'b0;
                    tb_byte  = 8'($urandom);
                end
            end
        end
    endtask

    initial begin
        sel      = 1'b0;
        tb_valid = 1'b0;
        tb_last  = 1'b0;
        tb_byte  = 8'h00;
        n_rst    = 1'b0;

        mk(0, 1, 1, 8'hA5, 8'h00);
        mk(1, 1, 1, 8'hFF, 8'h00);
        mk(2, 2, 2, 8'h3F, 8'h03);
        mk(3, 2, 2, 8'hFF, 8'hFF);
        mk(4, 2, 1, 8'h55, 8'hAA);
        for (int p = 5; p < 15; p++) gen(p);
        mk(15, 1, 1, 8'hA5, 8'h00);
        mk(16, 1, 1, 8'h01, 8'h00);
        for (int p = 17; p < 20; p++) gen(p);

        #1;
        chk("reset_outputs", 32'(obs), 32'h0);
        chk("reset_outputs4", 32'({d4, r4, e4, y4, u4, b4}), 32'h0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        run_packet(0, 1, 1'b1);
        chk("a5_busy_clks", 32'(c_busy), 32'd19);
        chk("a5_accepts", 32'(c_acc), 32'd1);
        chk("a5_stream", stream, 32'h0000_01A5);
        chk("a5_bit_en_tied", 32'(c_ben), 32'd0);

        run_packet(1, 1, 1'b1);
        chk("ff_ready_clks", 32'(c_ready), 32'd17);
        chk("ff_busy_clks", 32'(c_busy), 32'd20);
        chk("ff_stream", stream, 32'h0000_03F7);

        run_packet(2, 1, 1'b1);
        run_packet(3, 1, 1'b0);

        run_packet(4, 1, 1'b0);
        chk("und_accepts", 32'(c_acc), 32'd1);
        chk("und_pulses", 32'(c_und), 32'd1);
        chk("und_busy_clks", 32'(c_busy), 32'd19);

        for (int p = 5; p < 15; p++) run_packet(p, 1, p < 14);

        tb_byte  = 8'hC3;
        tb_last  = 1'b1;
        tb_valid = 1'b1;
        repeat (13) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(obs.busy), 32'd1);
        #1;
        n_rst = 1'b0;
        #1;
        chk("reset_async", 32'(obs), 32'h0);
        tb_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", 32'(obs), 32'h0);
        end
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        run_packet(15, 1, 1'b0);
        chk("post_reset_stream", stream, 32'h0000_01A5);

        sel = 1'b1;
        run_packet(16, 4, 1'b1);
        chk("cpb4_busy_clks", 32'(c_busy), 32'd76);
        chk("cpb4_bit_en", 32'(c_ben), 32'd19);
        chk("cpb4_ready_clks", 32'(c_ready), 32'd64);
        chk("cpb4_accepts", 32'(c_acc), 32'd1);

        for (int p = 17; p < 20; p++) run_packet(p, 4, p < 19);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
